dmem_if: RTL

Data-memory bus interface in the MEM stage, directly downstream of the `mmu` address/data/byte-enable generator. It takes the per-instruction memory request (`addrin`, `datain`, low-aligned `wen`, `mem_op`), lane-shifts it onto a handshaked data-memory bus, and stalls the pipeline until the access completes. For loads, it returns the extracted and sign- or zero-extended result. It also flags misaligned accesses and bus timeouts.

---
 rtl/dmem_if.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dmem_if.sv
// MEM-stage data-memory bus interface: lane-shifts mmu requests onto a gnt/rvalid
// handshaked bus, stalls the pipeline until completion and extends load data.
module dmem_if #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [4:0]  mem_op,
  input  logic [31:0] addrin,
  input  logic [31:0] datain,
  input  logic [3:0]  wen,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [3:0]  dm_wen,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        done,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        err
);
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] MEM_BYTE  = 2'b00;
  localparam logic [1:0] MEM_HALF  = 2'b01;
  localparam logic [1:0] MEM_WORD  = 2'b10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(TIMEOUT + 1);
  // The abort fires on the cycle whose increment would bring the count to TIMEOUT-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  logic [1:0]    state;
  logic [4:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [3:0]    wen_q;
  logic          mis_q;
  logic          tout_q;
  logic [CW-1:0] cnt;
  logic [31:0]   ld_q;

  logic          is_rd_in;
  logic          is_wr_in;
  logic          access;
  logic          misaligned;
  logic          expired;
  logic          rd_q;
  logic          wr_q;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_ext;

  assign is_rd_in   = mem_op[4:3] == MEM_READ;
  assign is_wr_in   = mem_op[4:3] == MEM_WRITE;
  assign access     = req_valid && (is_rd_in || is_wr_in);
  assign misaligned = ((mem_op[1:0] == MEM_HALF) && addrin[0]) ||
                      ((mem_op[1:0] == MEM_WORD) && (addrin[1:0] != 2'b00));
  assign rd_q       = op_q[4:3] == MEM_READ;
  assign wr_q       = op_q[4:3] == MEM_WRITE;
  assign expired    = cnt == CNT_LAST;
  assign rd_shift   = dm_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_ext = rd_shift;
    case (op_q[1:0])
      MEM_BYTE: ld_ext = op_q[2] ? {24'd0, rd_shift[7:0]}
                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
      MEM_HALF: ld_ext = op_q[2] ? {16'd0, rd_shift[15:0]}
                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default:  ld_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      wen_q  <= '0;
      mis_q  <= 1'b0;
      tout_q <= 1'b0;
      cnt    <= '0;
      ld_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            op_q   <= mem_op;
            addr_q <= addrin;
            data_q <= datain;
            wen_q  <= wen;
            mis_q  <= misaligned;
            tout_q <= 1'b0;
            cnt    <= '0;
            state  <= misaligned ? DONE : REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (dm_gnt) begin
            state <= wr_q ? DONE : WAIT;
          end else if (expired) begin
            tout_q <= 1'b1;
            ld_q   <= '0;
            state  <= DONE;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (dm_rvalid) begin
            ld_q  <= ld_ext;
            state <= DONE;
          end else if (expired) begin
            tout_q <= 1'b1;
            ld_q   <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          // Inputs still describe the completing instruction, so never re-accept here.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dm_req   = state == REQ;
  assign dm_addr  = dm_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dm_we    = dm_req && wr_q;
  assign dm_wen   = dm_we ? (wen_q << addr_q[1:0]) : 4'd0;
  assign dm_wdata = dm_we ? (data_q << {addr_q[1:0], 3'b000}) : 32'd0;
  assign stall    = rst && (((state == IDLE) && access) || (state == REQ) || (state == WAIT));
  assign done     = state == DONE;
  assign err      = done && (mis_q || tout_q);
  assign ld_valid = done && rd_q && !err;
  assign ld_data  = ld_q;

endmodule
